// File: rtl/cache_arbiter.sv
// -----------------------------------------------------------------------------
// cache_arbiter
//   Shares one physical-memory port between the instruction cache (i_*) and
//   the data cache (d_*). One line transaction is in flight at a time; a
//   three-state FSM (IDLE / SERVE_I / SERVE_D) owns the port, and ties are
//   broken round-robin against the side that started the previous transaction.
//   A completed transaction hands the port straight to a waiting other side
//   with no idle cycle in between.
//
// Optional feature macro: CACHE_ARB_PERF_EN
//   Adds i_grant_count / d_grant_count / conflict_count (32-bit, wrapping)
//   and the perf_reset input. Arbitration is identical with or without it.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   i_read, i_address   I-cache line read request (held until i_resp)
//   i_rdata, i_resp     I-cache read data / one-cycle completion pulse
//   d_read, d_write     D-cache line read / write request (mutually exclusive)
//   d_address, d_wdata  D-cache line address / write-back data
//   d_rdata, d_resp     D-cache read data / one-cycle completion pulse
//   pmem_read/write     memory strobes, held until pmem_resp
//   pmem_address/wdata  memory address / write data
//   pmem_rdata/resp     memory read data / completion pulse
// -----------------------------------------------------------------------------
module cache_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
`ifdef CACHE_ARB_PERF_EN
    ,
    output logic [31:0]           i_grant_count,
    output logic [31:0]           d_grant_count,
    output logic [31:0]           conflict_count,
    input  logic                  perf_reset
`endif
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SERVE_I = 2'd1;
    localparam logic [1:0] SERVE_D = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic       r_last_grant;     // 0 = I, 1 = D started most recently
    logic       w_next_last_grant;
    logic       w_i_req;
    logic       w_d_req;

    assign w_i_req = i_read;
    assign w_d_req = d_read | d_write;

    always_comb begin
        w_next_state      = r_state;
        w_next_last_grant = r_last_grant;
        case (r_state)
            IDLE: begin
                // On a tie, I wins only when D started last.
                if (w_i_req && (!w_d_req || r_last_grant)) begin
                    w_next_state      = SERVE_I;
                    w_next_last_grant = 1'b0;
                end else if (w_d_req) begin
                    w_next_state      = SERVE_D;
                    w_next_last_grant = 1'b1;
                end
            end
            SERVE_I: begin
                // The finishing side's request is still high this cycle,
                // so only the other side is considered for the handoff.
                if (pmem_resp) begin
                    if (w_d_req) begin
                        w_next_state      = SERVE_D;
                        w_next_last_grant = 1'b1;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            SERVE_D: begin
                if (pmem_resp) begin
                    if (w_i_req) begin
                        w_next_state      = SERVE_I;
                        w_next_last_grant = 1'b0;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;   // first tie after reset goes to I
        end else begin
            r_state      <= w_next_state;
            r_last_grant <= w_next_last_grant;
        end
    end

    // Downstream drive is purely a function of the owner; D strobes follow
    // the requester's inputs directly.
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        case (r_state)
            SERVE_I: begin
                pmem_read    = 1'b1;
                pmem_address = i_address;
            end
            SERVE_D: begin
                pmem_read    = d_read;
                pmem_write   = d_write;
                pmem_address = d_address;
                pmem_wdata   = d_wdata;
            end
            default: ;
        endcase
    end

    assign i_resp  = pmem_resp & (r_state == SERVE_I);
    assign d_resp  = pmem_resp & (r_state == SERVE_D);
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

`ifdef CACHE_ARB_PERF_EN
    logic [31:0] r_i_grant_count;
    logic [31:0] r_d_grant_count;
    logic [31:0] r_conflict_count;

    always_ff @(posedge clk) begin
        if (reset || perf_reset) begin
            r_i_grant_count  <= '0;
            r_d_grant_count  <= '0;
            r_conflict_count <= '0;
        end else begin
            if (i_resp)             r_i_grant_count  <= r_i_grant_count + 32'd1;
            if (d_resp)             r_d_grant_count  <= r_d_grant_count + 32'd1;
            // Only one side can ever be served, so both asserted == conflict.
            if (w_i_req && w_d_req) r_conflict_count <= r_conflict_count + 32'd1;
        end
    end

    assign i_grant_count  = r_i_grant_count;
    assign d_grant_count  = r_d_grant_count;
    assign conflict_count = r_conflict_count;
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_arbiter
//   Directed scenarios plus a randomized run against a transaction-level model
//   of port ownership. Inputs change 1 time unit after the rising edge,
//   outputs are sampled 4 units after it, and the model advances on the edge.
// -----------------------------------------------------------------------------
module tb_cache_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_read;
    logic [AW-1:0] i_address;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_address;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;
`ifdef CACHE_ARB_PERF_EN
    logic [31:0]   i_grant_count;
    logic [31:0]   d_grant_count;
    logic [31:0]   conflict_count;
    logic          perf_reset;
`endif

    cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk(clk), .reset(reset),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
`ifdef CACHE_ARB_PERF_EN
        , .i_grant_count(i_grant_count), .d_grant_count(d_grant_count),
        .conflict_count(conflict_count), .perf_reset(perf_reset)
`endif
    );

    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    // Model: who holds the memory port (0 none, 1 I, 2 D) and whether D
    // started the latest transaction.
    int          m_owner  = 0;
    bit          m_last_d = 1'b1;
    logic [31:0] m_icnt = 0, m_dcnt = 0, m_ccnt = 0;

    task automatic tick();
        bit pi, pd, pr, rs, prs;
        int fin;
        bit wi, wd;
        pi  = i_read;
        pd  = d_read | d_write;
        pr  = pmem_resp;
        rs  = reset;
        prs = 1'b0;
`ifdef CACHE_ARB_PERF_EN
        prs = perf_reset;
`endif
        @(posedge clk);
        if (rs || prs) begin
            m_icnt = 0; m_dcnt = 0; m_ccnt = 0;
        end else begin
            if (pr && m_owner == 1) m_icnt = m_icnt + 1;
            if (pr && m_owner == 2) m_dcnt = m_dcnt + 1;
            if (pi && pd)           m_ccnt = m_ccnt + 1;
        end
        if (rs) begin
            m_owner  = 0;
            m_last_d = 1'b1;
        end else begin
            // A finishing side cannot win again with the request it just
            // completed; the port is free whenever nobody holds it.
            fin = (m_owner != 0 && pr) ? m_owner : 0;
            if (m_owner == 0 || fin != 0) begin
                wi = pi && (fin != 1);
                wd = pd && (fin != 2);
                if (wi && wd)  m_owner = m_last_d ? 1 : 2;
                else if (wi)   m_owner = 1;
                else if (wd)   m_owner = 2;
                else           m_owner = 0;
                if (m_owner != 0) m_last_d = (m_owner == 2);
            end
        end
        #1;
    endtask

    task automatic clear_inputs();
        i_read = 0; i_address = '0; d_read = 0; d_write = 0;
        d_address = '0; d_wdata = '0; pmem_rdata = '0; pmem_resp = 0;
`ifdef CACHE_ARB_PERF_EN
        perf_reset = 0;
`endif
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        tick(); tick();
        reset = 0;
        #3;
        n_run++;
        if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0)
            $display("FAIL reset_strobes: got %b want 0000", {pmem_read, pmem_write, i_resp, d_resp});
        n_run++;
        if (pmem_address !== '0) $display("FAIL reset_addr: got %h want 0", pmem_address);
        n_run++;
        if (pmem_wdata !== '0) $display("FAIL reset_wdata: got %h want 0", pmem_wdata);
`ifdef CACHE_ARB_PERF_EN
        n_run++;
        if ({i_grant_count, d_grant_count, conflict_count} !== 96'd0)
            $display("FAIL reset_counters: got %h want 0", {i_grant_count, d_grant_count, conflict_count});
`endif
    endtask

    task automatic test_single_i();
        logic [LW-1:0] pat;
        pat = {32{8'hA5}};
        i_read = 1; i_address = 32'h100;
        #3;
        n_run++;
        if (pmem_read !== 1'b0) begin n_fail++; $display("FAIL single_i_latency: got %b want 0", pmem_read); end
        tick();
        for (int c = 0; c < 3; c++) begin
            pmem_resp  = (c == 2);
            pmem_rdata = (c == 2) ? pat : '0;
            #3;
            n_run++;
            if (pmem_read !== 1'b1 || pmem_address !== 32'h100) begin
                n_fail++; $display("FAIL single_i_drive c=%0d: got rd=%b addr=%h want rd=1 addr=100", c, pmem_read, pmem_address);
            end
            n_run++;
            if (i_resp !== (c == 2) || d_resp !== 1'b0) begin
                n_fail++; $display("FAIL single_i_resp c=%0d: got i=%b d=%b want i=%b d=0", c, i_resp, d_resp, (c == 2));
            end
            if (c == 2) begin
                n_run++;
                if (i_rdata !== pat) begin n_fail++; $display("FAIL single_i_rdata: got %h want %h", i_rdata, pat); end
            end
            tick();
        end
        i_read = 0; pmem_resp = 0;
        #3;
        n_run++;
        if (pmem_read !== 1'b0) begin n_fail++; $display("FAIL single_i_release: got %b want 0", pmem_read); end
        tick();
    endtask

    task automatic test_d_write();
        d_write = 1; d_address = 32'h200; d_wdata = 256'h1234;
        tick();
        for (int c = 0; c < 2; c++) begin
            pmem_resp = (c == 1);
            #3;
            n_run++;
            if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 32'h200 || pmem_wdata !== 256'h1234) begin
                n_fail++; $display("FAIL d_write_drive c=%0d: got w=%b r=%b addr=%h wdata=%h want w=1 r=0 addr=200 wdata=1234",
                                   c, pmem_write, pmem_read, pmem_address, pmem_wdata);
            end
            n_run++;
            if (d_resp !== (c == 1) || i_resp !== 1'b0) begin
                n_fail++; $display("FAIL d_write_resp c=%0d: got d=%b i=%b want d=%b i=0", c, d_resp, i_resp, (c == 1));
            end
            tick();
        end
        d_write = 0; d_wdata = '0; pmem_resp = 0;
        tick();
    endtask

    task automatic test_tie_handoff();
        reset = 1; tick(); reset = 0;
        i_read = 1; d_read = 1; i_address = 32'h300; d_address = 32'h400;
        tick();
        pmem_resp = 1;
        #3;
        n_run++;
        if (pmem_address !== 32'h300 || i_resp !== 1'b1) begin
            n_fail++; $display("FAIL tie_first_i: got addr=%h i_resp=%b want addr=300 i_resp=1", pmem_address, i_resp);
        end
        tick();
        i_read = 0; pmem_resp = 0;
        #3;
        n_run++;
        if (pmem_address !== 32'h400 || pmem_read !== 1'b1) begin
            n_fail++; $display("FAIL handoff_no_bubble: got addr=%h rd=%b want addr=400 rd=1", pmem_address, pmem_read);
        end
        pmem_resp = 1;
        #1;
        n_run++;
        if (d_resp !== 1'b1 || i_resp !== 1'b0) begin
            n_fail++; $display("FAIL handoff_d_resp: got d=%b i=%b want d=1 i=0", d_resp, i_resp);
        end
        tick();
        d_read = 0; pmem_resp = 0;
        tick();
        // I alone, so I is the most recent starter.
        i_read = 1; tick(); pmem_resp = 1; tick(); i_read = 0; pmem_resp = 0; tick();
        i_read = 1; d_read = 1;
        tick();
        #3;
        n_run++;
        if (pmem_address !== 32'h400) begin
            n_fail++; $display("FAIL tie_after_i_goes_d: got addr=%h want 400", pmem_address);
        end
        pmem_resp = 1;
        tick();
        d_read = 0; pmem_resp = 0;
        #3;
        n_run++;
        if (pmem_address !== 32'h300 || pmem_read !== 1'b1) begin
            n_fail++; $display("FAIL tie_second_handoff: got addr=%h rd=%b want addr=300 rd=1", pmem_address, pmem_read);
        end
        pmem_resp = 1;
        tick();
        i_read = 0; pmem_resp = 0;
        tick();
    endtask

    task automatic test_contention();
        bit exp_i;
        reset = 1; tick(); reset = 0;
        i_read = 1; d_read = 1; i_address = 32'h500; d_address = 32'h600;
        tick();
        for (int k = 0; k < 6; k++) begin
            exp_i = (k % 2 == 0);
            pmem_resp = 1;
            #3;
            n_run++;
            if (pmem_address !== (exp_i ? 32'h500 : 32'h600) || i_resp !== exp_i || d_resp !== !exp_i) begin
                n_fail++; $display("FAIL contention_k%0d: got addr=%h i=%b d=%b want i=%b", k, pmem_address, i_resp, d_resp, exp_i);
            end
            tick();
        end
`ifdef CACHE_ARB_PERF_EN
        n_run++;
        if (i_grant_count !== 32'd3 || d_grant_count !== 32'd3) begin
            n_fail++; $display("FAIL contention_grants: got i=%0d d=%0d want 3 3", i_grant_count, d_grant_count);
        end
        n_run++;
        if (conflict_count !== m_ccnt) begin
            n_fail++; $display("FAIL contention_conflicts: got %0d want %0d", conflict_count, m_ccnt);
        end
`endif
        i_read = 0; d_read = 0; pmem_resp = 0;
        reset = 1; tick(); reset = 0;
    endtask

    task automatic test_reset_mid_d();
        d_read = 1; d_address = 32'h700;
        tick();
        #3;
        n_run++;
        if (pmem_read !== 1'b1 || pmem_address !== 32'h700) begin
            n_fail++; $display("FAIL mid_d_start: got rd=%b addr=%h want rd=1 addr=700", pmem_read, pmem_address);
        end
        reset = 1;
        tick();
        reset = 0; d_read = 0; pmem_resp = 1;
        #3;
        n_run++;
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || d_resp !== 1'b0 || i_resp !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_d: got rd=%b wr=%b d=%b i=%b want 0 0 0 0", pmem_read, pmem_write, d_resp, i_resp);
        end
        tick();
        pmem_resp = 0;
        #3;
        n_run++;
        if (pmem_read !== 1'b0 || pmem_address !== '0) begin
            n_fail++; $display("FAIL late_resp_ignored: got rd=%b addr=%h want rd=0 addr=0", pmem_read, pmem_address);
        end
        tick();
    endtask

    task automatic test_stray_resp();
`ifdef CACHE_ARB_PERF_EN
        logic [95:0] before;
        before = {i_grant_count, d_grant_count, conflict_count};
`endif
        pmem_resp = 1; pmem_rdata = {8{32'hDEADBEEF}};
        #3;
        n_run++;
        if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
            n_fail++; $display("FAIL stray_resp: got i=%b d=%b want 0 0", i_resp, d_resp);
        end
        tick();
        pmem_resp = 0;
        #3;
        n_run++;
        if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
            n_fail++; $display("FAIL stray_state: got rd=%b wr=%b want 0 0", pmem_read, pmem_write);
        end
`ifdef CACHE_ARB_PERF_EN
        n_run++;
        if ({i_grant_count, d_grant_count, conflict_count} !== before) begin
            n_fail++; $display("FAIL stray_counters: got %h want %h", {i_grant_count, d_grant_count, conflict_count}, before);
        end
`endif
        tick();
    endtask

    task automatic test_random();
        int  lat;
        bit  prev_i, prev_d;
        logic er, ew, eir, edr;
        logic [AW-1:0] ea;
        logic [LW-1:0] ewd;
        lat = 0; prev_i = 0; prev_d = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            // Requesters hold until their completion pulse, then may drop.
            if (i_read && prev_i) i_read = 0;
            else if (!i_read && $urandom_range(0, 2) == 0) begin
                i_read = 1; i_address = $urandom;
            end
            if ((d_read || d_write) && prev_d) begin
                d_read = 0; d_write = 0;
            end else if (!(d_read || d_write) && $urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 1) d_write = 1; else d_read = 1;
                d_address = $urandom;
            end
            d_wdata    = {8{$urandom}};
            pmem_rdata = {8{$urandom}};
            if (m_owner != 0) begin
                if (lat == 0) begin pmem_resp = 1; lat = $urandom_range(0, 3); end
                else begin pmem_resp = 0; lat--; end
            end else begin
                pmem_resp = ($urandom_range(0, 7) == 0);
                lat = $urandom_range(0, 3);
            end
            er  = (m_owner == 1) ? 1'b1 : (m_owner == 2) ? d_read : 1'b0;
            ew  = (m_owner == 2) ? d_write : 1'b0;
            ea  = (m_owner == 1) ? i_address : (m_owner == 2) ? d_address : '0;
            ewd = (m_owner == 2) ? d_wdata : '0;
            eir = pmem_resp && (m_owner == 1);
            edr = pmem_resp && (m_owner == 2);
            prev_i = eir;
            prev_d = edr;
            #3;
            n_run++;
            if ({pmem_read, pmem_write, i_resp, d_resp} !== {er, ew, eir, edr}) begin
                n_fail++; $display("FAIL rand_ctrl cyc=%0d: got %b want %b", cyc, {pmem_read, pmem_write, i_resp, d_resp}, {er, ew, eir, edr});
            end
            n_run++;
            if (pmem_address !== ea || pmem_wdata !== ewd) begin
                n_fail++; $display("FAIL rand_data cyc=%0d: got addr=%h wdata=%h want addr=%h wdata=%h", cyc, pmem_address, pmem_wdata, ea, ewd);
            end
            n_run++;
            if (i_rdata !== pmem_rdata || d_rdata !== pmem_rdata) begin
                n_fail++; $display("FAIL rand_rdata cyc=%0d: got i=%h d=%h want %h", cyc, i_rdata, d_rdata, pmem_rdata);
            end
            tick();
        end
`ifdef CACHE_ARB_PERF_EN
        n_run++;
        if ({i_grant_count, d_grant_count, conflict_count} !== {m_icnt, m_dcnt, m_ccnt}) begin
            n_fail++; $display("FAIL rand_counters: got %h want %h", {i_grant_count, d_grant_count, conflict_count}, {m_icnt, m_dcnt, m_ccnt});
        end
        // perf_reset wins over a simultaneous conflict increment.
        i_read = 1; d_read = 1; d_write = 0; pmem_resp = 0; perf_reset = 1;
        tick();
        perf_reset = 0;
        n_run++;
        if ({i_grant_count, d_grant_count, conflict_count} !== 96'd0) begin
            n_fail++; $display("FAIL perf_reset: got %h want 0", {i_grant_count, d_grant_count, conflict_count});
        end
`endif
        clear_inputs();
        reset = 1; tick(); reset = 0;
    endtask

    initial begin
        int f0;
        test_reset();
        // Reset checks above only print; fold them into the failure count.
        f0 = 0;
        if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0 || pmem_address !== '0 || pmem_wdata !== '0) f0 = 1;
        n_fail += f0;
        test_single_i();
        test_d_write();
        test_tie_handoff();
        test_contention();
        test_reset_mid_d();
        test_stray_resp();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Two-requester arbiter that shares the single physical-memory port between the instruction cache, which serves the fetch stage's `read_a`/`resp_a` path, and the data cache. It sits between the two caches and main memory. It serialises line transactions through a three-state FSM with round-robin tie-breaking, and forwards each memory response only to the requester that owns the transaction.

## Interface

Parameters:
- `ADDR_WIDTH`, 32: address width of all ports.
- `LINE_WIDTH`, 256: cache-line data width.

Ports (`i_*` = instruction cache, `d_*` = data cache, `pmem_*` = physical memory):
- `clk`  in  1  sole clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `i_read`  in  1  I-cache line read request; held until `i_resp`.
- `i_address`  in  ADDR_WIDTH  I-cache line address.
- `i_rdata`  out  LINE_WIDTH  read data to I-cache.
- `i_resp`  out  1  one-cycle completion pulse to I-cache.
- `d_read`  in  1  D-cache line read request.
- `d_write`  in  1  D-cache line write request. Never asserted together with `d_read`.
- `d_address`  in  ADDR_WIDTH  D-cache line address.
- `d_wdata`  in  LINE_WIDTH  D-cache write-back line.
- `d_rdata`  out  LINE_WIDTH  read data to D-cache.
- `d_resp`  out  1  one-cycle completion pulse to D-cache.
- `pmem_read`  out  1  memory read strobe; held until `pmem_resp`.
- `pmem_write`  out  1  memory write strobe; held until `pmem_resp`.
- `pmem_address`  out  ADDR_WIDTH  memory address.
- `pmem_wdata`  out  LINE_WIDTH  memory write data.
- `pmem_rdata`  in  LINE_WIDTH  memory read data, valid with `pmem_resp`.
- `pmem_resp`  in  1  memory completion pulse.
- Present only with `CACHE_ARB_PERF_EN`:
  - `i_grant_count`  out  32  completed I transactions.
  - `d_grant_count`  out  32  completed D transactions.
  - `conflict_count`  out  32  cycles with both requesters waiting.
  - `perf_reset`  in  1  clears all three counters.

## Operation

- FSM states: `IDLE`, `SERVE_I`, `SERVE_D`.
- Register `last_grant` (0 = I, 1 = D) records the owner of the most recently *started* transaction.
- Transitions from `IDLE`:
  - `i_read` only → `SERVE_I`.
  - `d_read|d_write` only → `SERVE_D`.
  - Both pending → serve the side not equal to `last_grant`.
  - Neither pending → stay in `IDLE`.
- `SERVE_x` without `pmem_resp`: stay; no re-arbitration.
- `SERVE_x` with `pmem_resp`:
  - Other side pending → go directly to `SERVE_other` (no idle bubble) and update `last_grant`.
  - Otherwise → `IDLE`.
- `last_grant` is written on every entry into a `SERVE` state.
- Downstream drive, combinational from state:
  - `SERVE_I`: `pmem_read=1`, `pmem_write=0`, `pmem_address=i_address`.
  - `SERVE_D`: `pmem_read=d_read`, `pmem_write=d_write`, `pmem_address=d_address`, `pmem_wdata=d_wdata`.
  - `IDLE`: both strobes 0, address 0.
- Response routing:
  - `i_resp = pmem_resp & (state==SERVE_I)`; `d_resp = pmem_resp & (state==SERVE_D)`.
  - `i_rdata` and `d_rdata` both carry `pmem_rdata` unconditionally.
- Requester deasserting its request mid-transaction is a protocol violation. The arbiter still holds the state until `pmem_resp` and still emits the resp pulse. The downstream strobe follows the requester's input, so the memory model must tolerate this.
- `pmem_resp` in `IDLE` is ignored: no resp pulse, no state change.

## Timing

- Reset values:
  - State `IDLE`, `last_grant=1`, so the first tie goes to I.
  - All `pmem_*` outputs 0; `i_resp=d_resp=0`.
  - Counters 0.
- Arbitration latency: request seen in `IDLE` at edge N → `pmem_read`/`pmem_write` asserted from cycle N+1.
- Response latency: 0 cycles. `x_resp` is asserted in the same cycle as `pmem_resp`.
- Handoff: the cycle after a `pmem_resp`, the other side's strobe is already asserted when that side is pending.
- Reset mid-transaction: at the next edge the FSM returns to `IDLE` and strobes drop. The in-flight memory response is discarded.
- Counters (`CACHE_ARB_PERF_EN`):
  - `i_grant_count` / `d_grant_count` increment on each cycle with `i_resp` / `d_resp`.
  - `conflict_count` increments each cycle where the I request and a D request are asserted and the FSM is not serving both. That is every cycle with both requests asserted.
  - Counters wrap modulo 2^32.
  - `reset` or `perf_reset` clears them and has priority over increment.

## Configuration

- Macro `CACHE_ARB_PERF_EN`.
- Defined: the three 32-bit counters and `perf_reset` exist, with the behaviour in Timing.
- Undefined: those ports and registers are absent. Arbitration behaviour is identical in both builds.

## Test plan

- **Single I read:** `i_read=1`, `i_address=0x100`, memory responds after 3 cycles with `0xA5..A5` → `pmem_read` high for 3 cycles starting 1 cycle after the request; one `i_resp` pulse with `i_rdata=0xA5..A5`; `d_resp` stays 0.
- **D write:** `d_write=1`, `d_address=0x200`, `d_wdata=0x1234` → `pmem_write=1`, `pmem_address=0x200`, `pmem_wdata=0x1234` until resp; one `d_resp` pulse.
- **Simultaneous requests after reset:** I is served first. On its `pmem_resp`, the next cycle `pmem_address` is `d_address` with no `IDLE` cycle. Repeating the tie then serves D first.
- **Continuous contention:** both sides request for 6 transactions → grants strictly alternate I,D,I,D,I,D. With `CACHE_ARB_PERF_EN`, `i_grant_count=d_grant_count=3`.
- **Reset during `SERVE_D`:** assert `reset` before `pmem_resp` → next cycle state `IDLE`, strobes 0, no `d_resp`. A late `pmem_resp` is ignored.
- **Stray `pmem_resp` in `IDLE`:** pulse `pmem_resp` with no requests → `i_resp=d_resp=0`, state unchanged, counters unchanged.
